mag_peak_detect: RTL

Streaming peak detector directly downstream of the vector-magnitude stage. It consumes one unsigned magnitude per valid cycle and finds contiguous excursions above a hysteresis threshold pair. For each excursion it emits one event carrying the maximum magnitude, its sample timestamp and the excursion length, over a valid/ready handshake. Magnitude-stage latency is absorbed upstream by a matching valid delay line; this block sees only aligned `sink_valid`/`sink_mag`.

---
 rtl/mag_pkg.sv | 21 ++
 rtl/event_buffer.sv | 33 +++
 rtl/mag_peak_detect.sv | 110 +++++++++++
 3 files changed

// File: rtl/mag_pkg.sv
// Shared types for the magnitude peak detector: FSM states and the event record.
// Event fields are sized for the widest supported instance; narrower instances zero-extend.
package mag_pkg;

  localparam int PKG_WIDTH   = 16;
  localparam int PKG_TSWIDTH = 32;
  localparam int PKG_LWIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEAK = 2'd1,
    HOLD = 2'd2
  } peak_state_t;

  typedef struct packed {
    logic [PKG_WIDTH-1:0]   peak;
    logic [PKG_TSWIDTH-1:0] tstamp;
    logic [PKG_LWIDTH-1:0]  len;
  } peak_event_t;

endpackage

// File: rtl/event_buffer.sv
// One-entry valid/ready event register. A new event is accepted when the slot is empty
// or being drained this cycle; otherwise it is dropped and the sticky overrun flag set.
module event_buffer
  import mag_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  peak_event_t ev,
  input  logic        ready,
  output logic        valid,
  output peak_event_t data,
  output logic        overrun
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid   <= 1'b0;
      data    <= '0;
      overrun <= 1'b0;
    end else if (load) begin
      if (!valid || ready) begin
        valid <= 1'b1;
        data  <= ev;
      end else begin
        overrun <= 1'b1;
      end
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mag_peak_detect.sv
// Streaming hysteresis peak detector: tracks each excursion above thr_hi until it falls
// below thr_lo, then emits {peak, timestamp, length} through a one-entry output buffer.
module mag_peak_detect
  import mag_pkg::*;
#(
  parameter int WIDTH   = PKG_WIDTH,
  parameter int TSWIDTH = PKG_TSWIDTH,
  parameter int LWIDTH  = PKG_LWIDTH,
  parameter int HOLDOFF = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sink_valid,
  input  logic [WIDTH-1:0]   sink_mag,
  input  logic [WIDTH-1:0]   thr_hi,
  input  logic [WIDTH-1:0]   thr_lo,
  output logic               source_valid,
  input  logic               source_ready,
  output logic [WIDTH-1:0]   source_peak,
  output logic [TSWIDTH-1:0] source_time,
  output logic [LWIDTH-1:0]  source_len,
  output logic               overrun
);

  localparam int HCW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  peak_state_t        state, state_nxt;
  logic [TSWIDTH-1:0] ts_cnt;
  logic [HCW-1:0]     hold_cnt;
  logic [WIDTH-1:0]   peak_max;
  logic [TSWIDTH-1:0] peak_ts;
  logic [LWIDTH-1:0]  exc_len;
  logic               start_hit, end_hit, close_evt;
  peak_event_t        ev, out_ev;

  function automatic logic [LWIDTH-1:0] sat_inc(input logic [LWIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign start_hit = (sink_mag >= thr_hi);
  assign end_hit   = (sink_mag < thr_lo);
  assign close_evt = sink_valid && (state == PEAK) && end_hit;

  always_comb begin
    state_nxt = state;
    if (sink_valid) begin
      case (state)
        IDLE:    if (start_hit) state_nxt = PEAK;
        PEAK:    if (end_hit) state_nxt = (HOLDOFF == 0) ? IDLE : HOLD;
        HOLD:    if (hold_cnt <= HCW'(1)) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ts_cnt   <= '0;
      hold_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (sink_valid) begin
        ts_cnt <= ts_cnt + 1'b1;
        if (state == PEAK && end_hit) hold_cnt <= HCW'(HOLDOFF);
        else if (state == HOLD) hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

  // Excursion payload: overwritten at every start, so it carries no reset.
  always_ff @(posedge clk) begin
    if (sink_valid) begin
      if (state == IDLE && start_hit) begin
        peak_max <= sink_mag;
        peak_ts  <= ts_cnt;
        exc_len  <= LWIDTH'(1);
      end else if (state == PEAK && !end_hit) begin
        exc_len <= sat_inc(exc_len);
        if (sink_mag > peak_max) begin
          peak_max <= sink_mag;
          peak_ts  <= ts_cnt;
        end
      end
    end
  end

  always_comb begin
    ev = '0;
    ev.peak[WIDTH-1:0]     = peak_max;
    ev.tstamp[TSWIDTH-1:0] = peak_ts;
    ev.len[LWIDTH-1:0]     = exc_len;
  end

  event_buffer u_event_buffer (
    .clk     (clk),
    .reset   (reset),
    .load    (close_evt),
    .ev      (ev),
    .ready   (source_ready),
    .valid   (source_valid),
    .data    (out_ev),
    .overrun (overrun)
  );

  assign source_peak = out_ev.peak[WIDTH-1:0];
  assign source_time = out_ev.tstamp[TSWIDTH-1:0];
  assign source_len  = out_ev.len[LWIDTH-1:0];

endmodule
